// File: rtl/seg_scan_if.sv
// Bundle of display pins, control and recovered results for the 7-segment scan capture block.
// master = stimulus/driver side, slave = capture block.
interface seg_scan_if;
    logic [3:0]  enable_in;
    logic [6:0]  segments_in;
    logic        clear;
    logic [15:0] digits_out;
    logic [3:0]  valid_out;
    logic [3:0]  blank_out;
    logic [3:0]  bad_pat;
    logic        frame_done;

    modport master (
        output enable_in, segments_in, clear,
        input  digits_out, valid_out, blank_out, bad_pat, frame_done
    );

    modport slave (
        input  enable_in, segments_in, clear,
        output digits_out, valid_out, blank_out, bad_pat, frame_done
    );
endinterface

// File: rtl/seg_scan_capture.sv
// Recovers the hex value shown on each digit of a 4-digit multiplexed active-low 7-segment display.
// Patterns must hold STABLE_CYCLES synchronised cycles before they are decoded and stored.
module seg_scan_capture #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic      clk,
    input  logic      rst,
    seg_scan_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    // Result is {bad, blank, value}.
    function automatic logic [5:0] decode(input logic [6:0] seg);
        case (seg)
            7'h40:   decode = {2'b00, 4'h0};
            7'h79:   decode = {2'b00, 4'h1};
            7'h24:   decode = {2'b00, 4'h2};
            7'h30:   decode = {2'b00, 4'h3};
            7'h19:   decode = {2'b00, 4'h4};
            7'h12:   decode = {2'b00, 4'h5};
            7'h02:   decode = {2'b00, 4'h6};
            7'h78:   decode = {2'b00, 4'h7};
            7'h00:   decode = {2'b00, 4'h8};
            7'h10:   decode = {2'b00, 4'h9};
            7'h08:   decode = {2'b00, 4'hA};
            7'h03:   decode = {2'b00, 4'hB};
            7'h46:   decode = {2'b00, 4'hC};
            7'h21:   decode = {2'b00, 4'hD};
            7'h06:   decode = {2'b00, 4'hE};
            7'h0E:   decode = {2'b00, 4'hF};
            7'h7F:   decode = {2'b01, 4'h0};
            default: decode = {2'b10, 4'h0};
        endcase
    endfunction

    logic [3:0]       en_m_q, en_s_q, en_p_q;
    logic [6:0]       seg_m_q, seg_s_q, seg_p_q;
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [15:0]      digits_q;
    logic [3:0]       valid_q, blank_q, bad_q, mask_q, mask_d;
    logic             fdone_q;

    logic             onehot, same, capture;
    logic [1:0]       sel;
    logic [5:0]       dec;

    always_comb begin
        onehot  = $onehot(~en_s_q);
        same    = ({en_s_q, seg_s_q} == {en_p_q, seg_p_q});
        dec     = decode(seg_s_q);
        sel     = 2'd0;
        case (en_s_q)
            4'b1101: sel = 2'd1;
            4'b1011: sel = 2'd2;
            4'b0111: sel = 2'd3;
            default: sel = 2'd0;
        endcase
        capture = (state_q == SETTLE) && same && (cnt_q == CNT_LAST);
        // A completed frame empties the mask the cycle frame_done is raised.
        mask_d  = (mask_q == 4'hF) ? 4'h0 : mask_q;
        if (capture) mask_d[sel] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_m_q   <= 4'hF;
            en_s_q   <= 4'hF;
            en_p_q   <= 4'hF;
            seg_m_q  <= 7'h7F;
            seg_s_q  <= 7'h7F;
            seg_p_q  <= 7'h7F;
            state_q  <= IDLE;
            cnt_q    <= '0;
            digits_q <= '0;
            valid_q  <= '0;
            blank_q  <= '0;
            bad_q    <= '0;
            mask_q   <= '0;
            fdone_q  <= 1'b0;
        end else begin
            en_m_q  <= bus.enable_in;
            en_s_q  <= en_m_q;
            en_p_q  <= en_s_q;
            seg_m_q <= bus.segments_in;
            seg_s_q <= seg_m_q;
            seg_p_q <= seg_s_q;
            if (bus.clear) begin
                state_q  <= IDLE;
                cnt_q    <= '0;
                digits_q <= '0;
                valid_q  <= '0;
                blank_q  <= '0;
                bad_q    <= '0;
                mask_q   <= '0;
                fdone_q  <= 1'b0;
            end else begin
                fdone_q <= (mask_q == 4'hF);
                mask_q  <= mask_d;
                case (state_q)
                    IDLE: begin
                        cnt_q <= '0;
                        if (onehot) state_q <= SETTLE;
                    end
                    SETTLE: begin
                        if (!same) begin
                            cnt_q   <= '0;
                            state_q <= onehot ? SETTLE : IDLE;
                        end else if (cnt_q == CNT_LAST) begin
                            cnt_q   <= '0;
                            state_q <= HELD;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        if (!same) begin
                            cnt_q   <= '0;
                            state_q <= onehot ? SETTLE : IDLE;
                        end
                    end
                endcase
                if (capture) begin
                    if (dec[5]) begin
                        bad_q[sel]   <= 1'b1;
                        valid_q[sel] <= 1'b0;
                        blank_q[sel] <= 1'b0;
                    end else if (dec[4]) begin
                        valid_q[sel] <= 1'b0;
                        blank_q[sel] <= 1'b1;
                    end else begin
                        digits_q[{sel, 2'b00} +: 4] <= dec[3:0];
                        valid_q[sel] <= 1'b1;
                        blank_q[sel] <= 1'b0;
                    end
                end
            end
        end
    end

    assign bus.digits_out = digits_q;
    assign bus.valid_out  = valid_q;
    assign bus.blank_out  = blank_q;
    assign bus.bad_pat    = bad_q;
    assign bus.frame_done = fdone_q;
endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture: expected display state is queued per future cycle
// when stimulus is driven, and compared on the falling edge when that cycle arrives.
module tb_seg_scan_capture;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seg_scan_if bus();

    seg_scan_capture #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        int          cyc;
        logic [15:0] d;
        logic [3:0]  v;
        logic [3:0]  b;
        logic [3:0]  bad;
        int          fd;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    int   fd_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Count frame_done pulses first so queued entries see the pulse of their own cycle.
    always @(negedge clk) begin : mon
        exp_t e;
        if (bus.frame_done === 1'b1) fd_cnt++;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            checks++;
            assert (e.cyc == cyc &&
                    {bus.digits_out, bus.valid_out, bus.blank_out, bus.bad_pat} === {e.d, e.v, e.b, e.bad} &&
                    fd_cnt == e.fd)
            else begin
                errors++;
                $error("FAIL %s: got d=%h v=%b b=%b bad=%b fd=%0d cyc=%0d, want d=%h v=%b b=%b bad=%b fd=%0d cyc=%0d",
                       e.tag, bus.digits_out, bus.valid_out, bus.blank_out, bus.bad_pat, fd_cnt, cyc,
                       e.d, e.v, e.b, e.bad, e.fd, e.cyc);
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] en, input logic [6:0] seg);
        bus.enable_in   = en;
        bus.segments_in = seg;
    endtask

    task automatic expect_at(input int dly, input logic [15:0] d, input logic [3:0] v,
                             input logic [3:0] b, input logic [3:0] bad, input int fd,
                             input string tag);
        exp_t e;
        e.cyc = cyc + dly;
        e.d   = d;
        e.v   = v;
        e.b   = b;
        e.bad = bad;
        e.fd  = fd;
        e.tag = tag;
        q.push_back(e);
    endtask

    task automatic check_zero(input string tag);
        checks++;
        assert ({bus.digits_out, bus.valid_out, bus.blank_out, bus.bad_pat, bus.frame_done} === 29'd0)
        else begin
            errors++;
            $error("FAIL %s: got d=%h v=%b b=%b bad=%b fd=%b, want all zero",
                   tag, bus.digits_out, bus.valid_out, bus.blank_out, bus.bad_pat, bus.frame_done);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.clear = 1'b0;
        drive(4'hF, 7'h7F);
        wait_cyc(3);
        check_zero("reset_state");
        rst = 1'b0;
        wait_cyc(3);

        // Single digit 0 showing "2": latency is 7 clocks from the pin change.
        drive(4'b1110, 7'h24);
        expect_at(6, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 0, "lat_before");
        expect_at(7, 16'h0002, 4'b0001, 4'b0000, 4'b0000, 0, "dig0_2");
        wait_cyc(10);

        // Full scan 0,4,A,F; one frame pulse after digit 3.
        drive(4'b1110, 7'h40);
        expect_at(7, 16'h0000, 4'b0001, 4'b0000, 4'b0000, 0, "scan_d0");
        wait_cyc(8);
        drive(4'b1101, 7'h19);
        expect_at(7, 16'h0040, 4'b0011, 4'b0000, 4'b0000, 0, "scan_d1");
        wait_cyc(8);
        drive(4'b1011, 7'h08);
        expect_at(7, 16'h0A40, 4'b0111, 4'b0000, 4'b0000, 0, "scan_d2");
        wait_cyc(8);
        drive(4'b0111, 7'h0E);
        expect_at(7, 16'hFA40, 4'b1111, 4'b0000, 4'b0000, 0, "scan_d3");
        expect_at(8, 16'hFA40, 4'b1111, 4'b0000, 4'b0000, 1, "frame_pulse");
        wait_cyc(8);

        // Illegal pattern on digit 2 is sticky.
        drive(4'b1011, 7'h55);
        expect_at(7, 16'hFA40, 4'b1011, 4'b0000, 4'b0100, 1, "bad_d2");
        wait_cyc(8);
        drive(4'b1011, 7'h46);
        expect_at(7, 16'hFC40, 4'b1111, 4'b0000, 4'b0100, 1, "bad_sticky");
        wait_cyc(8);

        // Three-cycle "8" glitch is ignored; the following "1" is captured.
        drive(4'b1101, 7'h00);
        wait_cyc(3);
        drive(4'b1101, 7'h79);
        expect_at(4, 16'hFC40, 4'b1111, 4'b0000, 4'b0100, 1, "glitch_no8");
        expect_at(7, 16'hFC10, 4'b1111, 4'b0000, 4'b0100, 1, "dig1_1");
        wait_cyc(8);

        // Two enables low: nothing captured.
        drive(4'b1100, 7'h79);
        expect_at(10, 16'hFC10, 4'b1111, 4'b0000, 4'b0100, 1, "two_low_10");
        expect_at(20, 16'hFC10, 4'b1111, 4'b0000, 4'b0100, 1, "two_low_20");
        wait_cyc(20);

        // Clear on the capture edge wins; the held pattern is then recaptured from IDLE.
        drive(4'b0111, 7'h06);
        wait_cyc(6);
        bus.clear = 1'b1;
        wait_cyc(1);
        bus.clear = 1'b0;
        expect_at(0, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 1, "clear_capture");
        expect_at(1, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 1, "clear_no_pulse");
        expect_at(5, 16'hE000, 4'b1000, 4'b0000, 4'b0000, 1, "recap_d3");
        wait_cyc(8);

        // Mask was cleared: digit 0 alone does not complete a frame.
        drive(4'b1110, 7'h30);
        expect_at(7, 16'hE003, 4'b1001, 4'b0000, 4'b0000, 1, "d0_3");
        expect_at(8, 16'hE003, 4'b1001, 4'b0000, 4'b0000, 1, "d0_nopulse");
        wait_cyc(8);
        drive(4'b1110, 7'h7F);
        expect_at(7, 16'hE003, 4'b1000, 4'b0001, 4'b0000, 1, "blank_d0");
        wait_cyc(8);
        drive(4'b1101, 7'h21);
        expect_at(7, 16'hE0D3, 4'b1010, 4'b0001, 4'b0000, 1, "d1_d");
        wait_cyc(8);
        drive(4'b1011, 7'h12);
        expect_at(7, 16'hE5D3, 4'b1110, 4'b0001, 4'b0000, 1, "d2_5");
        expect_at(8, 16'hE5D3, 4'b1110, 4'b0001, 4'b0000, 2, "frame2");
        wait_cyc(8);

        // Async reset in the middle of settling discards the partial count.
        drive(4'b1110, 7'h12);
        wait_cyc(3);
        rst = 1'b1;
        #1;
        check_zero("rst_async");
        wait_cyc(1);
        rst = 1'b0;
        expect_at(3, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 2, "rst_midsettle");
        expect_at(6, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 2, "post_rst_early");
        expect_at(7, 16'h0005, 4'b0001, 4'b0000, 4'b0000, 2, "post_rst_cap");

        for (int i = 0; i < 50 && q.size() > 0; i++) wait_cyc(1);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
